// File: rtl/pcpu_pkg.sv
// Shared pipeline types for the pcpu core.
// Fetch FSM encodings and reset vector live here.
package pcpu_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PCPU_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] word_align(
    input logic [31:0] p
  );
    return p & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request,
// a hold register feeding IF/ID, redirect flushes.
module fetch_unit
  import pcpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PCPU_RESET_PC
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic [15:0] drop_cnt
);

  fetch_state_t state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] hold;
  logic        hold_q;
  logic        req_q;
  logic        drop;
  logic        cap;
  logic [31:0] tgt;
  logic        req_fire;

  assign tgt      = word_align(redirect_pc);
  assign req_fire = req_q & imem_req_ready;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    drop    = 1'b0;
    cap     = 1'b0;
    unique case (state)
      S_REQ: begin
        if (redirect_valid) begin
          pc_n    = tgt;
          state_n = req_fire ? S_DROP : S_REQ;
        end else if (req_fire) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_n    = tgt;
          drop    = imem_rsp_valid;
          state_n = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          cap     = 1'b1;
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_n    = tgt;
          state_n = S_REQ;
        end else if (if_ready) begin
          pc_n    = pc + 32'd4;
          state_n = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_valid) pc_n = tgt;
        if (imem_rsp_valid) begin
          drop    = 1'b1;
          state_n = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase
  end

  // Output flags are registered off the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      hold     <= 32'h0;
      hold_q   <= 1'b0;
      req_q    <= 1'b0;
      drop_cnt <= 16'h0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      req_q  <= (state_n == S_REQ);
      hold_q <= (state_n == S_HOLD);
      if (cap) hold <= imem_rsp_data;
      if (drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign imem_req_valid = req_q;
  assign imem_req_addr  = pc;
  assign if_valid       = hold_q & ~redirect_valid;
  assign if_pc          = pc;
  assign if_instr       = hold;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit.
// Expected values are hand-derived per scenario.
module tb_fetch_unit;

  logic        clk;
  logic        rstn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic [15:0] drop_cnt;

  int n_checks;
  int n_fail;

  fetch_unit dut (
    .clk            (clk),
    .rstn           (rstn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready),
    .drop_cnt       (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full fetch at zero wait: REQ, WAIT, HOLD.
  task automatic do_fetch(
    input logic [31:0] exp_pc,
    input logic [31:0] instr
  );
    check("req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("req_addr", imem_req_addr, exp_pc);
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    check("wait_req_low", {31'b0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = instr;
    cyc();
    imem_rsp_valid = 1'b0;
    check("if_valid", {31'b0, if_valid}, 32'd1);
    check("if_pc", if_pc, exp_pc);
    check("if_instr", if_instr, instr);
    if_ready = 1'b1;
    cyc();
    if_ready = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rstn           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if_ready       = 1'b0;

    #3;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_addr", imem_req_addr, 32'h0);
    check("rst_drop", {16'b0, drop_cnt}, 32'd0);
    check("rst_instr", if_instr, 32'h0);

    #9;
    rstn = 1'b1;
    #1;
    check("rel_req_low", {31'b0, imem_req_valid}, 32'd0);
    cyc();

    // Sequential stream, 3 cycles per instruction.
    do_fetch(32'h0, 32'h0000_0013);
    do_fetch(32'h4, 32'h0010_0093);
    do_fetch(32'h8, 32'h0020_0113);
    do_fetch(32'hC, 32'h0030_0193);

    // Stall in HOLD at pc 0x10.
    check("pc10_addr", imem_req_addr, 32'h10);
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hA5A5_5A5A;
    cyc();
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'b0, if_valid}, 32'd1);
      check("stall_pc", if_pc, 32'h10);
      check("stall_instr", if_instr, 32'hA5A5_5A5A);
      check("stall_noreq", {31'b0, imem_req_valid}, 32'd0);
      cyc();
    end
    if_ready = 1'b1;
    cyc();
    if_ready = 1'b0;
    check("post_stall_addr", imem_req_addr, 32'h14);

    // Redirect in WAIT, response two cycles later.
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cyc();
    redirect_valid = 1'b0;
    check("drop_noreq", {31'b0, imem_req_valid}, 32'd0);
    cyc();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    cyc();
    imem_rsp_valid = 1'b0;
    check("drop_cnt1", {16'b0, drop_cnt}, 32'd1);
    check("drop_ifv", {31'b0, if_valid}, 32'd0);
    check("redir_req", {31'b0, imem_req_valid}, 32'd1);
    check("redir_addr", imem_req_addr, 32'h200);

    // Redirect in HOLD beats the handshake; low bits dropped.
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111_2222;
    cyc();
    imem_rsp_valid = 1'b0;
    check("hold200_valid", {31'b0, if_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    if_ready       = 1'b1;
    #1;
    check("hold_redir_ifv", {31'b0, if_valid}, 32'd0);
    cyc();
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    check("hold_redir_req", {31'b0, imem_req_valid}, 32'd1);
    check("hold_redir_addr", imem_req_addr, 32'h100);
    check("hold_redir_drop", {16'b0, drop_cnt}, 32'd1);

    // Redirect in REQ without acceptance, then wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    do_fetch(32'hFFFF_FFFC, 32'h0000_006F);
    check("wrap_addr", imem_req_addr, 32'h0);
    check("wrap_req", {31'b0, imem_req_valid}, 32'd1);

    // Redirect in REQ with acceptance goes through DROP.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    imem_req_ready = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    check("reqdrop_noreq", {31'b0, imem_req_valid}, 32'd0);
    check("reqdrop_addr", imem_req_addr, 32'h300);
    imem_rsp_valid = 1'b1;
    cyc();
    imem_rsp_valid = 1'b0;
    check("reqdrop_cnt", {16'b0, drop_cnt}, 32'd2);
    check("reqdrop_req", {31'b0, imem_req_valid}, 32'd1);

    // Redirect with same-cycle response in WAIT.
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    imem_rsp_valid = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    check("same_drop", {16'b0, drop_cnt}, 32'd3);
    check("same_req", {31'b0, imem_req_valid}, 32'd1);
    check("same_addr", imem_req_addr, 32'h400);

    // Stray response in REQ is ignored.
    imem_rsp_valid = 1'b1;
    cyc();
    imem_rsp_valid = 1'b0;
    check("stray_req", {31'b0, imem_req_valid}, 32'd1);
    check("stray_ifv", {31'b0, if_valid}, 32'd0);
    check("stray_drop", {16'b0, drop_cnt}, 32'd3);

    // Reset while waiting at pc 0x40.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    cyc();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    check("w40_addr", imem_req_addr, 32'h40);
    rstn = 1'b0;
    #1;
    check("mrst_req", {31'b0, imem_req_valid}, 32'd0);
    check("mrst_addr", imem_req_addr, 32'h0);
    check("mrst_drop", {16'b0, drop_cnt}, 32'd0);
    check("mrst_ifv", {31'b0, if_valid}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    cyc();
    do_fetch(32'h0, 32'h0000_0073);
    check("final_addr", imem_req_addr, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
